// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU): restoring shift-subtract, one
// quotient bit per cycle, with a fast path for divide-by-zero and signed overflow.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr_out
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic [4:0]      rd_q;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] dvs;
  logic [2*XLEN:0] work;
  logic [CW-1:0]   cnt;

  logic            is_signed;
  logic            is_rem;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] special_res;
  logic [XLEN+1:0] trial;
  logic [2*XLEN:0] work_next;
  logic [XLEN-1:0] quo_fixed;
  logic [XLEN-1:0] rem_fixed;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    is_signed   = ~op[0];
    is_rem      = op[1];
    a_neg       = is_signed & rs1_data[XLEN-1];
    b_neg       = is_signed & rs2_data[XLEN-1];
    abs_a       = a_neg ? -rs1_data : rs1_data;
    abs_b       = b_neg ? -rs2_data : rs2_data;
    div_zero    = (rs2_data == '0);
    overflow    = is_signed && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    special_res = '0;
    if (div_zero)
      special_res = is_rem ? rs1_data : '1;
    else if (overflow)
      special_res = is_rem ? '0 : rs1_data;
  end

  // Trial subtraction on the shifted partial remainder; a borrow means restore.
  always_comb begin
    trial     = work[2*XLEN:XLEN-1] - {2'b00, dvs};
    work_next = {work[2*XLEN-1:0], 1'b0};
    if (!trial[XLEN+1])
      work_next = {trial[XLEN:0], work[XLEN-2:0], 1'b1};
  end

  always_comb begin
    quo_fixed = (neg_a ^ neg_b) ? -work[XLEN-1:0] : work[XLEN-1:0];
    rem_fixed = neg_a ? -work[2*XLEN-1:XLEN] : work[2*XLEN-1:XLEN];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      dvs         <= '0;
      work        <= '0;
      cnt         <= '0;
      result      <= '0;
      rd_addr_out <= '0;
    end else if (flush && state != IDLE) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q  <= op;
            rd_q  <= rd_addr_in;
            neg_a <= a_neg;
            neg_b <= b_neg;
            dvs   <= abs_b;
            work  <= {{(XLEN+1){1'b0}}, abs_a};
            cnt   <= '0;
            if (div_zero || overflow) begin
              result      <= special_res;
              rd_addr_out <= rd_addr_in;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          work <= work_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1))
            state <= FIX;
        end
        FIX: begin
          result      <= op_q[1] ? rem_fixed : quo_fixed;
          rd_addr_out <= rd_q;
          state       <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A flush landing in the DONE cycle must kill the pulse before writeback sees it.
  assign busy = (state != IDLE);
  assign done = (state == DONE) && !flush;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed/unsigned results, special
// cases, flush behaviour and start/reset protocol.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr_in(rd_addr_in),
    .flush(flush), .busy(busy), .done(done), .result(result),
    .rd_addr_out(rd_addr_out)
  );

  always #5 clk = ~clk;

  // Issues one request and waits for done; lat counts edges from accept to the
  // done cycle (-1 on timeout), busy_cyc counts cycles busy was seen high.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output int busy_cyc,
                        output logic [31:0] res, output logic [4:0] rdo);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs1_data = a; rs2_data = b; rd_addr_in = rd;
    lat = -1;
    busy_cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        lat = i;
        break;
      end
    end
    res = result;
    rdo = rd_addr_out;
  endtask

  task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat);
    int lat, bc;
    logic [31:0] res;
    logic [4:0] rdo;
    run_op(o, a, b, rd, lat, bc, res, rdo);
    total++;
    if (lat !== exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    total++;
    if (res !== exp_res) begin
      bad++;
      $display("FAIL %s result: got %h expected %h", name, res, exp_res);
    end
    total++;
    if (rdo !== rd) begin
      bad++;
      $display("FAIL %s rd_addr_out: got %0d expected %0d", name, rdo, rd);
    end
    total++;
    if (bc !== exp_lat) begin
      bad++;
      $display("FAIL %s busy cycles: got %0d expected %0d", name, bc, exp_lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0;
    rs1_data = '0; rs2_data = '0; rd_addr_in = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, result, rd_addr_out} !== 39'd0) begin
      bad++;
      $display("FAIL reset outputs: got busy=%b done=%b result=%h rd=%0d expected all 0",
               busy, done, result, rd_addr_out);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    check_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 34);
    check_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 5'd4, 32'd2, 34);
    check_op("divu_max_16", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 5'd31, 32'h0FFF_FFFF, 34);
  endtask

  task automatic test_signed();
    check_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 34);
    check_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 34);
    check_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'd1, 34);
    check_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'hFFFF_FFFD, 34);
  endtask

  task automatic test_div_zero();
    check_op("div_5_0", OP_DIV, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);
    check_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 5'd10, 32'd5, 1);
  endtask

  task automatic test_overflow();
    check_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    check_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1);
  endtask

  task automatic test_flush_calc();
    logic [31:0] prev_res;
    logic [4:0]  prev_rd;
    int pulses;
    prev_res = result;
    prev_rd  = rd_addr_out;
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; rs1_data = 32'd100; rs2_data = 32'd7; rd_addr_in = 5'd20;
    @(posedge clk); #1;                 // cycle N+1
    start = 1'b0;
    repeat (9) @(posedge clk);          // cycle N+10
    #1 flush = 1'b1;
    @(posedge clk); #1;                 // cycle N+11
    flush = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL flush_calc busy: got %b expected 0", busy);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL flush_calc activity: got %0d busy/done cycles expected 0", pulses);
    end
    total++;
    if (result !== prev_res || rd_addr_out !== prev_rd) begin
      bad++;
      $display("FAIL flush_calc hold: got %h/%0d expected %h/%0d",
               result, rd_addr_out, prev_res, prev_rd);
    end
  endtask

  task automatic test_flush_done();
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIV; rs1_data = 32'd5; rs2_data = 32'd0; rd_addr_in = 5'd21;
    @(posedge clk); #1;                 // DONE cycle
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b1) begin
      bad++;
      $display("FAIL flush_done pre: got busy=%b done=%b expected 1/1", busy, done);
    end
    flush = 1'b1;
    #1;
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL flush_done done: got %b expected 0", done);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL flush_done post: got busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_start_flush();
    int pulses;
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = OP_DIVU; rs1_data = 32'd9; rs2_data = 32'd3; rd_addr_in = 5'd22;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy || done) pulses++;
      @(posedge clk); #1;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL start_flush accept: got %0d busy/done cycles expected 0", pulses);
    end
  endtask

  task automatic test_hold_start();
    int pulses, first;
    @(posedge clk); #1;
    start = 1'b1; op = OP_REMU; rs1_data = 32'd1000; rs2_data = 32'd7; rd_addr_in = 5'd23;
    pulses = 0;
    first = -1;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        if (first < 0) first = i;
        start = 1'b0;
      end
    end
    start = 1'b0;
    total++;
    if (pulses !== 1 || first !== 34) begin
      bad++;
      $display("FAIL hold_start: got %0d pulses first at %0d expected 1 at 34", pulses, first);
    end
    total++;
    if (result !== 32'd6 || rd_addr_out !== 5'd23) begin
      bad++;
      $display("FAIL hold_start result: got %h/%0d expected 6/23", result, rd_addr_out);
    end
  endtask

  task automatic test_back_to_back();
    check_op("b2b_first", OP_DIVU, 32'd81, 32'd9, 5'd1, 32'd9, 34);
    check_op("b2b_second", OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd2, 32'hFFFF_FFFE, 34);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; rs1_data = 32'd500; rs2_data = 32'd3; rd_addr_in = 5'd25;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, result, rd_addr_out} !== 39'd0) begin
      bad++;
      $display("FAIL reset_mid outputs: got busy=%b done=%b result=%h rd=%0d expected all 0",
               busy, done, result, rd_addr_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_op("after_reset", OP_DIVU, 32'd500, 32'd3, 5'd26, 32'd166, 34);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_flush_calc();
    test_flush_done();
    test_start_flush();
    test_hold_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
